// File: rtl/rf_pkg.sv
// Shared constants and packing helpers for the multi-port register file.
package rf_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   // Low bit of port idx within a flat bus of w-bit fields.
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and issue buses of the multi-port register file.
interface regfile_mp_if #(
   parameter int DATA_W = rf_pkg::DATA_W,
   parameter int ADDR_W = rf_pkg::ADDR_W,
   parameter int NRD    = 2,
   parameter int NWR    = 2
);
   logic [NRD*ADDR_W-1:0] rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        rd_busy;
   logic [NWR-1:0]        wr_en;
   logic [NWR*ADDR_W-1:0] wr_addr;
   logic [NWR*DATA_W-1:0] wr_data;
   logic                  iss_en;
   logic [ADDR_W-1:0]     iss_addr;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      input  rd_data, rd_busy
   );
   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: zero register, write bypass and pending flag.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int DATA_W   = rf_pkg::DATA_W,
   parameter int ADDR_W   = rf_pkg::ADDR_W,
   parameter int NWR      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic [ADDR_W-1:0]     rd_addr,
   input  logic [NWR-1:0]        wr_eff,
   input  logic [NWR*ADDR_W-1:0] wr_addr,
   input  logic [NWR*DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0]     mem [1<<ADDR_W],
   input  logic [(1<<ADDR_W)-1:0] pending,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_busy
);
   always_comb begin
      rd_data = mem[rd_addr];
      rd_busy = pending[rd_addr];
      if (BYPASS != 0) begin
         // Ascending scan: the highest-index matching writer is forwarded.
         for (int j = 0; j < NWR; j++) begin
            if (wr_eff[j] && wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] == rd_addr) begin
               rd_data = wr_data[slice_lo(j, DATA_W) +: DATA_W];
               rd_busy = 1'b0;
            end
         end
      end
      if (ZERO_REG != 0 && rd_addr == '0) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised NRD-read / NWR-write register file with producer scoreboard.
module regfile_mp #(
   parameter int DATA_W   = rf_pkg::DATA_W,
   parameter int ADDR_W   = rf_pkg::ADDR_W,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input logic         clk,
   input logic         reset,
   regfile_mp_if.slave bus
);
   import rf_pkg::*;

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [DEPTH-1:0]  pending_reg;
   logic [DEPTH-1:0]  pending_next;
   logic [NWR-1:0]    wr_eff;
   logic              iss_eff;

   for (genvar gi = 0; gi < NWR; gi++) begin : g_wr
      assign wr_eff[gi] = bus.wr_en[gi] &&
                          !(ZERO_REG != 0 && bus.wr_addr[gi*ADDR_W +: ADDR_W] == '0);
   end

   assign iss_eff = bus.iss_en && !(ZERO_REG != 0 && bus.iss_addr == '0);

   // Completions clear first so a same-cycle issue to that entry stays pending.
   always_comb begin
      pending_next = pending_reg;
      for (int j = 0; j < NWR; j++) begin
         if (wr_eff[j])
            pending_next[bus.wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]] = 1'b0;
      end
      if (iss_eff)
         pending_next[bus.iss_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++)
            mem_reg[k] <= '0;
         pending_reg <= '0;
      end else begin
         // Later (higher-index) assignments override earlier ones.
         for (int j = 0; j < NWR; j++) begin
            if (wr_eff[j])
               mem_reg[bus.wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]] <=
                  bus.wr_data[slice_lo(j, DATA_W) +: DATA_W];
         end
         pending_reg <= pending_next;
      end
   end

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [DATA_W-1:0] port_data;
      logic              port_busy;

      rf_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .NWR      (NWR),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_rd (
         .rd_addr (bus.rd_addr[gi*ADDR_W +: ADDR_W]),
         .wr_eff  (wr_eff),
         .wr_addr (bus.wr_addr),
         .wr_data (bus.wr_data),
         .mem     (mem_reg),
         .pending (pending_reg),
         .rd_data (port_data),
         .rd_busy (port_busy)
      );

      assign bus.rd_data[gi*DATA_W +: DATA_W] = port_data;
      assign bus.rd_busy[gi]                  = port_busy;
   end
endmodule
